// File: rtl/dram_bist_ctrl.sv
// Two-pass march BIST sequencer for an array of RAM32X2S distributed-RAM slices.
// Writes pat(a,0), checks it, writes the complement, checks it, then reports results.
module dram_bist_ctrl #(
  parameter int NUM_SLICES = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [2*NUM_SLICES-1:0] ram_wdata,
  output logic                    ram_we,
  input  logic [2*NUM_SLICES-1:0] ram_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [5:0]              err_count,
  output logic [ADDR_W-1:0]       first_err_addr,
  output logic                    first_err_pass
);

  localparam int DW = 2 * NUM_SLICES;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [5:0] ERR_MAX = 6'd63;

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;
  state_t state;

  // Address bits repeated LSB-first across the word, optionally complemented.
  function automatic logic [DW-1:0] pat(input logic [ADDR_W-1:0] a, input logic p);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = a[i % ADDR_W] ^ p;
    return r;
  endfunction

  logic                    rd_phase;
  logic                    rd_active;
  logic                    err_inc;
  logic [5:0]              err_next;
  logic [ADDR_W-1:0]       addr_inc;

  always_comb begin
    rd_phase  = (state == RD1);
    rd_active = (state == RD0) || (state == RD1);
    err_inc   = rd_active && (ram_rdata != pat(ram_addr, rd_phase));
    err_next  = (err_inc && err_count != ERR_MAX) ? err_count + 6'd1 : err_count;
    addr_inc  = ram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_we         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_pass <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WR0;
            ram_addr       <= '0;
            ram_wdata      <= pat('0, 1'b0);
            ram_we         <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_pass <= 1'b0;
          end
        end
        WR0, WR1: begin
          if (ram_addr == ADDR_LAST) begin
            // Dropping WE here guarantees no write during any read cycle.
            state    <= (state == WR0) ? RD0 : RD1;
            ram_addr <= '0;
            ram_we   <= 1'b0;
          end else begin
            ram_addr  <= addr_inc;
            ram_wdata <= pat(addr_inc, state == WR1);
          end
        end
        RD0, RD1: begin
          err_count <= err_next;
          // err_count never returns to zero once set, so it marks the first error.
          if (err_inc && err_count == 6'd0) begin
            first_err_addr <= ram_addr;
            first_err_pass <= rd_phase;
          end
          if (ram_addr == ADDR_LAST) begin
            ram_addr <= '0;
            if (state == RD0) begin
              state     <= WR1;
              ram_we    <= 1'b1;
              ram_wdata <= pat('0, 1'b1);
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 6'd0);
            end
          end else begin
            ram_addr <= addr_inc;
          end
        end
        default: begin
          state  <= IDLE;
          ram_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_bist_ctrl.sv
// Bench for dram_bist_ctrl: behavioural 32x8 async-read RAM with injectable faults
// and a scoreboard of expected run results popped when done rises.
module tb_dram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_count;
  logic [4:0] first_err_addr;
  logic       first_err_pass;

  int checks = 0;
  int errors = 0;

  // 0 clean, 1 bit4 stuck at 0, 2 A4 ignored, 3 read data inverted
  int fault = 0;

  typedef struct {
    int     err;
    int     faddr;
    bit     fpass;
    bit     ok;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dram_bist_ctrl #(.NUM_SLICES(4), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_pass(first_err_pass)
  );

  logic [7:0] mem [0:31];
  logic [4:0] eff_addr;

  always_comb begin
    eff_addr = (fault == 2) ? {1'b0, ram_addr[3:0]} : ram_addr;
    ram_rdata = mem[eff_addr];
    if (fault == 1) ram_rdata[4] = 1'b0;
    if (fault == 3) ram_rdata = ~ram_rdata;
  end

  always @(posedge clk) begin
    if (ram_we) mem[eff_addr] <= ram_wdata;
  end

  function automatic logic [7:0] exp_pat(input logic [4:0] a, input logic p);
    return {a[2:0], a} ^ {8{p}};
  endfunction

  task automatic start_run(input int err, input int faddr, input bit fpass, input bit ok);
    exp_t e;
    e.err = err; e.faddr = faddr; e.fpass = fpass; e.ok = ok;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask

  // Follows one run from its first busy cycle, checks the bus trace, then the results.
  task automatic monitor_run(input string name, input int repulse_k);
    int k = 0;
    int bad = 0;
    exp_t e;
    logic [1:0] ph;
    logic       exp_we;
    while (busy === 1'b1 && k < 200) begin
      ph = 2'(k / 32);
      exp_we = ~ph[0];
      if (ram_addr !== 5'(k % 32) || ram_we !== exp_we || done !== 1'b0 ||
          (exp_we && ram_wdata !== exp_pat(5'(k % 32), ph[1])))
        bad++;
      start = (k == repulse_k);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s bus_trace: %0d bad cycles, required 0", name, bad);
    end
    checks++;
    if (k !== 128 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s run_length: busy %0d cycles done=%b, required 128 cycles done=1", name, k, done);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: empty at done", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (err_count !== 6'(e.err) || pass !== e.ok) begin
        errors++;
        $display("FAIL %s result: err_count=%0d pass=%b, required err_count=%0d pass=%b",
                 name, err_count, pass, e.err, e.ok);
      end
      checks++;
      if (first_err_addr !== 5'(e.faddr) || first_err_pass !== e.fpass) begin
        errors++;
        $display("FAIL %s first_err: addr=%0d pass=%b, required addr=%0d pass=%b",
                 name, first_err_addr, first_err_pass, e.faddr, e.fpass);
      end
      $display("run %s: err_count=%0d pass=%b first_err=%0d/%b", name, err_count, pass,
               first_err_addr, first_err_pass);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({ram_we, busy, done, pass, err_count, first_err_addr, first_err_pass, ram_addr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL %s outputs: we=%b busy=%b done=%b pass=%b err=%0d fa=%0d fp=%b addr=%0d wd=%h, required all 0",
               name, ram_we, busy, done, pass, err_count, first_err_addr, first_err_pass, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
    $display("reset: outputs idle");
  endtask

  task automatic test_clean();
    fault = 0;
    start_run(0, 0, 1'b0, 1'b1);
    monitor_run("clean", -1);
  endtask

  task automatic test_stuck_bit4();
    fault = 1;
    start_run(32, 16, 1'b0, 1'b0);
    monitor_run("stuck_bit4", -1);
  endtask

  task automatic test_alias_a4();
    fault = 2;
    start_run(32, 0, 1'b0, 1'b0);
    monitor_run("alias_a4", -1);
  endtask

  task automatic test_invert();
    fault = 3;
    start_run(63, 0, 1'b0, 1'b0);
    monitor_run("invert_saturate", -1);
  endtask

  task automatic test_start_held();
    exp_t e;
    fault = 0;
    e.err = 0; e.faddr = 0; e.fpass = 1'b0; e.ok = 1'b1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_count !== 6'd0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL start_held restart: busy=%b done=%b err=%0d pass=%b, required 1 0 0 0",
               busy, done, err_count, pass);
    end
    monitor_run("start_held", 3);
  endtask

  task automatic test_back_to_back();
    fault = 0;
    start_run(0, 0, 1'b0, 1'b1);
    monitor_run("repulse_at_40", 40);
  endtask

  task automatic test_async_reset();
    exp_t e;
    fault = 0;
    start_run(0, 0, 1'b0, 1'b1);
    repeat (10) begin
      start = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (ram_addr !== 5'd10 || ram_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset setup: addr=%0d we=%b busy=%b, required 10 1 1", ram_addr, ram_we, busy);
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    e = sb.pop_front();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_async_reset");
    $display("async reset: outputs cleared mid-WR0");
    start_run(0, 0, 1'b0, 1'b1);
    monitor_run("fresh_after_reset", -1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_clean();
    test_stuck_bit4();
    test_alias_a4();
    test_invert();
    test_start_held();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
